// File: rtl/conv_mem_arbiter.sv
// Single-port SRAM arbiter sharing the conv1d scratch memory between the accelerator and the MCU.
// Optional MCU starvation guard enabled by defining CONV_ARB_STARVE_GUARD_EN.
module conv_mem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_active,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic              mcu_gnt,
  output logic              mcu_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned WAIT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Out-of-range MAX_WAIT leaves an empty marker block in the elaborated hierarchy.
  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_max_wait_out_of_range
  end

  logic             force_mcu;
  logic             acc_rvalid_d, acc_rvalid_q;
  logic             mcu_rvalid_d, mcu_rvalid_q;
  logic [CNT_W-1:0] conflict_cnt_d, conflict_cnt_q;

`ifdef CONV_ARB_STARVE_GUARD_EN
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] mcu_wait_d, mcu_wait_q;

  assign force_mcu = acc_active & mcu_req & (mcu_wait_q == WAIT_LIMIT);

  // Cycles the MCU has been kept waiting; cleared on grant or idle.
  always_comb begin
    mcu_wait_d = '0;
    if (mcu_req && !mcu_gnt) begin
      mcu_wait_d = (mcu_wait_q == WAIT_LIMIT) ? mcu_wait_q : mcu_wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcu_wait_q <= '0;
    end else begin
      mcu_wait_q <= mcu_wait_d;
    end
  end
`else
  assign force_mcu = 1'b0;
`endif

  // Same-cycle grant; priority follows acc_active, nothing is granted during reset.
  always_comb begin
    acc_gnt = 1'b0;
    mcu_gnt = 1'b0;
    if (!rst) begin
      if (acc_active) begin
        acc_gnt = acc_req & ~force_mcu;
        mcu_gnt = mcu_req & (~acc_req | force_mcu);
      end else begin
        mcu_gnt = mcu_req;
        acc_gnt = acc_req & ~mcu_req;
      end
    end
  end

  // SRAM command mux; idle bus is driven to zero.
  always_comb begin
    mem_req   = acc_gnt | mcu_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc_gnt) begin
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
    end else if (mcu_gnt) begin
      mem_we    = mcu_we;
      mem_addr  = mcu_addr;
      mem_wdata = mcu_wdata;
    end
  end

  always_comb begin
    acc_rvalid_d   = acc_gnt & ~acc_we;
    mcu_rvalid_d   = mcu_gnt & ~mcu_we;
    conflict_cnt_d = conflict_cnt_q;
    if (stat_clr) begin
      conflict_cnt_d = '0;
    end else if (acc_req && mcu_req && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_rvalid_q   <= 1'b0;
      mcu_rvalid_q   <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      acc_rvalid_q   <= acc_rvalid_d;
      mcu_rvalid_q   <= mcu_rvalid_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign acc_rvalid   = acc_rvalid_q;
  assign mcu_rvalid   = mcu_rvalid_q;
  assign conflict_cnt = conflict_cnt_q;
  assign rdata        = mem_rdata;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed self-checking bench for conv_mem_arbiter (guard expectations follow CONV_ARB_STARVE_GUARD_EN).
module tb_conv_mem_arbiter;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 8;
`ifdef CONV_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              acc_active;
  logic              acc_req, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_gnt, acc_rvalid;
  logic              mcu_req, mcu_we;
  logic [ADDR_W-1:0] mcu_addr;
  logic [DATA_W-1:0] mcu_wdata;
  logic              mcu_gnt, mcu_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stat_clr;
  logic [15:0]       conflict_cnt;

  int checks   = 0;
  int failures = 0;

  conv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .acc_active(acc_active),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_gnt(mcu_gnt), .mcu_rvalid(mcu_rvalid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_clr(stat_clr), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; acc_active = 1'b0; stat_clr = 1'b0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    mcu_req = 1'b0; mcu_we = 1'b0; mcu_addr = '0; mcu_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("idle_acc_gnt", 32'(acc_gnt), 32'd0);
      check_eq("idle_mcu_gnt", 32'(mcu_gnt), 32'd0);
      check_eq("idle_mem_req", 32'(mem_req), 32'd0);
      check_eq("idle_rvalid", 32'({acc_rvalid, mcu_rvalid}), 32'd0);
      check_eq("idle_cnt", 32'(conflict_cnt), 32'd0);
      check_eq("idle_bus", 32'({mem_we, mem_addr}) | mem_wdata, 32'd0);
      @(posedge clk);
    end
    #1;

    // Accelerator priority: acc read 0x005 beats MCU write 0x3FF
    acc_active = 1'b1;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 10'h005;
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 10'h3FF; mcu_wdata = 32'hDEADBEEF;
    #1;
    check_eq("ap_acc_gnt", 32'(acc_gnt), 32'd1);
    check_eq("ap_mcu_gnt", 32'(mcu_gnt), 32'd0);
    check_eq("ap_mem_addr", 32'(mem_addr), 32'h005);
    check_eq("ap_mem_we", 32'(mem_we), 32'd0);
    tick();
    acc_req = 1'b0;
    #1;
    check_eq("ap_acc_rvalid", 32'(acc_rvalid), 32'd1);
    check_eq("ap_mcu_gnt2", 32'(mcu_gnt), 32'd1);
    check_eq("ap_mem_we2", 32'(mem_we), 32'd1);
    check_eq("ap_mem_addr2", 32'(mem_addr), 32'h3FF);
    check_eq("ap_mem_wdata2", mem_wdata, 32'hDEADBEEF);
    check_eq("ap_cnt", 32'(conflict_cnt), 32'd1);
    tick();
    mcu_req = 1'b0; mcu_we = 1'b0;
    #1;
    check_eq("ap_wr_no_rvalid", 32'({acc_rvalid, mcu_rvalid}), 32'd0);

    // MCU priority with both reading
    acc_active = 1'b0;
    acc_req = 1'b1; acc_addr = 10'h010;
    mcu_req = 1'b1; mcu_addr = 10'h020;
    #1;
    check_eq("mp_mcu_gnt", 32'(mcu_gnt), 32'd1);
    check_eq("mp_acc_gnt", 32'(acc_gnt), 32'd0);
    check_eq("mp_mem_addr", 32'(mem_addr), 32'h020);
    tick();
    mcu_req = 1'b0; mem_rdata = 32'hCAFE0001;
    #1;
    check_eq("mp_mcu_rvalid", 32'(mcu_rvalid), 32'd1);
    check_eq("mp_acc_rvalid0", 32'(acc_rvalid), 32'd0);
    check_eq("mp_acc_gnt2", 32'(acc_gnt), 32'd1);
    check_eq("mp_mem_addr2", 32'(mem_addr), 32'h010);
    check_eq("mp_rdata", rdata, 32'hCAFE0001);
    check_eq("mp_cnt", 32'(conflict_cnt), 32'd2);
    tick();
    acc_req = 1'b0;
    #1;
    check_eq("mp_acc_rvalid", 32'(acc_rvalid), 32'd1);
    check_eq("mp_mcu_rvalid0", 32'(mcu_rvalid), 32'd0);

    // Back-to-back accelerator reads
    acc_req = 1'b1; acc_addr = 10'h001;
    #1;
    check_eq("bb_gnt1", 32'(acc_gnt), 32'd1);
    tick();
    acc_addr = 10'h002;
    #1;
    check_eq("bb_rvalid1", 32'(acc_rvalid), 32'd1);
    check_eq("bb_addr2", 32'(mem_addr), 32'h002);
    tick();
    acc_req = 1'b0;
    #1;
    check_eq("bb_rvalid2", 32'(acc_rvalid), 32'd1);
    check_eq("bb_gnt_off", 32'(acc_gnt), 32'd0);
    tick();
    check_eq("bb_rvalid_off", 32'(acc_rvalid), 32'd0);

    // Starvation under accelerator priority
    acc_active = 1'b1;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 10'h100;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 10'h200;
    for (int k = 1; k <= 100; k++) begin
      #1;
      check_eq($sformatf("sv_mcu_gnt_c%0d", k), 32'(mcu_gnt), 32'(GUARD && (k % 9 == 0)));
      check_eq($sformatf("sv_acc_gnt_c%0d", k), 32'(acc_gnt), 32'(!(GUARD && (k % 9 == 0))));
      @(posedge clk);
    end
    #1;

    // Conflict counter saturation and clear
    repeat (65540) @(posedge clk);
    #1;
    check_eq("cnt_sat", 32'(conflict_cnt), 32'h0000FFFF);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check_eq("cnt_clr", 32'(conflict_cnt), 32'd0);
    tick();
    check_eq("cnt_after_clr", 32'(conflict_cnt), 32'd1);

    // Reset while an MCU read is pending
    acc_req = 1'b0; acc_active = 1'b0;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 10'h055;
    #1;
    check_eq("rs_mcu_gnt", 32'(mcu_gnt), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rs_gnt_in_rst", 32'({acc_gnt, mcu_gnt, mem_req}), 32'd0);
    tick();
    check_eq("rs_rvalid_drop", 32'(mcu_rvalid), 32'd0);
    check_eq("rs_cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0; mcu_req = 1'b0;
    tick();
    check_eq("rs_rvalid_idle", 32'(mcu_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_mem_arbiter.md
# conv_mem_arbiter

Single-port memory arbiter that shares the conv1d scratch SRAM between the accelerator control unit and the MCU bus port. It replaces the static idle-time handover to the MCU: both masters can issue requests at any time, and the arbiter grants one access per cycle. It returns read-valid strobes aligned to the SRAM's one-cycle read latency and bounds MCU starvation while the accelerator is running. It sits between the accelerator CU/datapath, the MCU slave port and the SRAM macro.

## Interface
Parameters:
- ADDR_W, 10, SRAM word-address width
- DATA_W, 32, SRAM data width
- MAX_WAIT, 8, MCU wait cycles before a forced grant (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- acc_active  in  1  accelerator running flag; selects the priority mode
- acc_req / acc_we  in  1 / 1  accelerator access request / write enable
- acc_addr / acc_wdata  in  ADDR_W / DATA_W  accelerator address / write data
- acc_gnt  out  1  accelerator access issued this cycle
- acc_rvalid  out  1  accelerator read data on rdata this cycle
- mcu_req / mcu_we  in  1 / 1  MCU access request / write enable
- mcu_addr / mcu_wdata  in  ADDR_W / DATA_W  MCU address / write data
- mcu_gnt  out  1  MCU access issued this cycle
- mcu_rvalid  out  1  MCU read data on rdata this cycle
- rdata  out  DATA_W  mem_rdata passed straight through
- mem_req / mem_we  out  1 / 1  SRAM request / write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  SRAM address / write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read mem_req
- stat_clr  in  1  clears conflict_cnt
- conflict_cnt  out  16  saturating count of cycles with both requests asserted

## Operation
- Grant decision (combinational, same cycle as request):
  - The requester holds req/we/addr/wdata stable until it sees gnt.
  - At most one gnt is high per cycle.
  - mem_req = acc_gnt | mcu_gnt.
  - mem_we/addr/wdata come from the granted master. They are 0 when no master is granted.
- Priority when acc_active=0: MCU first. The accelerator is granted only when mcu_req=0.
- Priority when acc_active=1: accelerator first. The MCU is granted when acc_req=0, or by a forced grant (see Configuration).
- mcu_wait counter (8 bit):
  - Increments each cycle that mcu_req=1 and mcu_gnt=0, saturating at MAX_WAIT.
  - Clears to 0 in any cycle with mcu_gnt=1 or mcu_req=0.
- Read return:
  - acc_rvalid is registered from acc_gnt & ~acc_we.
  - mcu_rvalid is registered from mcu_gnt & ~mcu_we.
  - Writes never produce rvalid.
- conflict_cnt:
  - +1 each cycle with acc_req & mcu_req, saturating at 0xFFFF.
  - stat_clr wins over a simultaneous increment (result 0).
- acc_active may toggle at any cycle. The new priority applies in that same cycle, and mcu_wait is not cleared by the toggle.

## Timing
- Grant latency: 0 cycles when uncontended. A losing master waits at least 1 cycle.
- Read latency: rvalid exactly 1 cycle after gnt. Back-to-back reads from the same master give rvalid on consecutive cycles.
- Interleaved reads from both masters: each rvalid is routed to its issuer, never to both in one cycle.
- Reset values:
  - Registered outputs: acc_rvalid=0, mcu_rvalid=0, conflict_cnt=0. Internal mcu_wait=0.
  - Combinational outputs with no requests: gnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset while a read is in flight: the pending rvalid is dropped. A re-request is required.
- rst overrides all other inputs in the same edge.

## Configuration
- CONV_ARB_STARVE_GUARD_EN defined:
  - While acc_active=1, mcu_req=1 and mcu_wait==MAX_WAIT, the MCU is granted even if acc_req=1.
  - The accelerator is stalled for exactly that cycle. mcu_wait then clears.
- Macro undefined:
  - Strict accelerator priority while acc_active=1. The MCU may starve indefinitely.
  - The mcu_wait register is not instantiated.

## Test plan
- Reset, then hold all requests low for 5 cycles -> all gnt/rvalid/mem_req 0, conflict_cnt=0.
- acc_active=1; accelerator reads addr 0x005 while MCU writes 0x3FF/0xDEADBEEF in the same cycle -> acc_gnt=1 and mem_addr=0x005. The next cycle gives acc_rvalid=1, and mcu_gnt=1 with mem_we=1, mem_addr=0x3FF. conflict_cnt=1.
- acc_active=0 with both requesting reads -> MCU granted first. mcu_rvalid the next cycle while acc_gnt=1. acc_rvalid the cycle after.
- Guard enabled, MAX_WAIT=8, acc_req and mcu_req held high with acc_active=1 -> mcu_gnt=1 on the 9th cycle, acc_gnt=0 that cycle, then accelerator priority resumes. With the macro undefined -> mcu_gnt stays 0 for 100 cycles.
- Both requests held for 70000 cycles -> conflict_cnt saturates at 0xFFFF. stat_clr with both requesting -> 0 the next cycle.
- MCU read granted, rst=1 on the following edge -> mcu_rvalid=0 after that edge, and no grant while rst=1.
